// File: rtl/drca_issue_ctrl.sv
// Issue/capture controller for the DRCA dynamic ripple-carry adder.
// Waits a data-dependent number of cycles set by the longest propagate run.
module drca_issue_ctrl #(
  parameter int N            = 16,
  parameter int BITS_PER_CYC = 4,
  parameter int CNT_W        = 32,
  localparam int CW = $clog2(N / BITS_PER_CYC + 2),
  localparam int LW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_A,
  input  logic [N-1:0]     in_B,
  input  logic             in_Cin,
  output logic             add_enable,
  output logic [N-1:0]     add_A,
  output logic [N-1:0]     add_B,
  output logic             add_Cin,
  input  logic [N-1:0]     add_S,
  input  logic             add_Cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:0]       out_sum,
  output logic [CW-1:0]    out_cycles,
  output logic [CNT_W-1:0] busy_total,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] w_q;
  logic [N-1:0]  prop;
  logic [LW-1:0] run;
  logic [LW-1:0] best;
  logic [CW-1:0] w_calc;

  // Longest run of propagate bits bounds the ripple distance.
  always_comb begin
    prop = in_A ^ in_B;
    run  = '0;
    best = '0;
    for (int i = 0; i < N; i++) begin
      if (prop[i]) run = run + LW'(1);
      else         run = '0;
      if (run > best) best = run;
    end
    w_calc = CW'(best / LW'(BITS_PER_CYC)) + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      add_enable <= 1'b0;
      add_A      <= '0;
      add_B      <= '0;
      add_Cin    <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_cycles <= '0;
      busy_total <= '0;
      ops_done   <= '0;
      cnt        <= '0;
      w_q        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            add_A      <= in_A;
            add_B      <= in_B;
            add_Cin    <= in_Cin;
            cnt        <= w_calc;
            w_q        <= w_calc;
            in_ready   <= 1'b0;
            add_enable <= 1'b1;
            state      <= EVAL;
          end
        end
        EVAL: begin
          cnt <= cnt - CW'(1);
          if (~&busy_total)
            busy_total <= busy_total + CNT_W'(1);
          if (cnt == CW'(1)) begin
            out_sum    <= {add_Cout, add_S};
            out_cycles <= w_q;
            out_valid  <= 1'b1;
            add_enable <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (~&ops_done)
              ops_done <= ops_done + CNT_W'(1);
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
